seq_freq_display: RTL
=====================

Name: seq_freq_display

Overview:
- Downstream consumer of the sequencer and throttle status outputs.
- Converts the sequence number (seq_num) and throttle frequency index (freq_num) from binary to decimal with a serial double-dabble engine.
- Drives the six active-low 7-segment displays: HEX2..HEX0 show seq_num, HEX5..HEX3 show freq_num.
- Runs on CLK_50 and re-converts whenever either input changes.

Parameters:
SEQ_W, 8, width of seq_num; legal range 1..9, so the value is at most 511 and fits three digits
FREQ_W, 8, width of freq_num; legal range 1..9
BLANK_LZ, 1, 1 = blank leading zeros (units digit always shown); 0 = show all three digits

Ports:
CLK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
seq_num  in  SEQ_W  current sequence number, unsigned
freq_num  in  FREQ_W  current throttle frequency index, unsigned
busy  out  1  high while a conversion is in progress
HEX0  out  7  seq units digit
HEX1  out  7  seq tens digit
HEX2  out  7  seq hundreds digit
HEX3  out  7  freq units digit
HEX4  out  7  freq tens digit
HEX5  out  7  freq hundreds digit

Behaviour:
- Segment coding: active-low, bit6=g … bit0=a.
  - Digits 0–9 = 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10.
  - Blank = 0x7F.
- Input synchronization: both inputs pass through a 2-flop synchronizer in CLK_50, because they originate from logic on slow_clk. The synced values are s_seq and s_freq.
- Conversion width: W = max(SEQ_W, FREQ_W). The narrower operand is zero-extended.
- FSM states: IDLE, LOAD, SHIFT, UPDATE.
  - IDLE: go to LOAD when valid=0 or {s_seq, s_freq} != {last_seq, last_freq}. Otherwise stay.
  - LOAD (1 cycle):
    - Snapshot s_seq and s_freq into the shift registers and into last_seq and last_freq.
    - Clear both 12-bit BCD accumulators.
    - Set busy=1.
    - Bit counter := W.
  - SHIFT (exactly W cycles), per cycle, for each operand independently:
    - Add 3 to every BCD nibble that is >= 5.
    - Shift {bcd, bin} left by 1.
    - Decrement the counter.
    - Exit to UPDATE when the counter reaches 0.
  - UPDATE (1 cycle):
    - Register all six HEX outputs from the BCD result, with blanking applied.
    - Set valid=1 and busy=0.
    - Return to IDLE.
- Latency:
  - busy is high for W+1 cycles (LOAD plus SHIFT).
  - With synced inputs stable, HEX updates on the W+2-th edge after leaving IDLE.
  - An input change at the pins becomes visible on HEX within W+5 edges; that is 13 edges for W=8.
- Input change during LOAD/SHIFT/UPDATE: ignored by the in-flight conversion. It is detected in IDLE on return, which triggers a new conversion. No update is dropped or merged incorrectly.
- Leading-zero blanking (BLANK_LZ=1):
  - Hundreds digit blanked if 0.
  - Tens digit blanked if both hundreds and tens are 0.
  - Units digit never blanked.
  - Applied per operand.
- Outputs hold their value between conversions. HEX never shows intermediate BCD values.
- Reset (async, any state):
  - All HEX outputs = 0x7F, busy=0, state=IDLE, valid=0, last_* = 0, accumulators cleared.
  - After release, the first conversion starts unconditionally because valid=0.
- Arithmetic: each BCD nibble stays <= 9 after every shift. This holds by construction for W <= 9.

Test Plan:
- Reset asserted → HEX0–HEX5 all 0x7F, busy=0. Release with seq=0, freq=0 → busy high for 9 cycles. Then HEX0=0x40, HEX1=HEX2=0x7F, HEX3=0x40, HEX4=HEX5=0x7F.
- seq=255, freq=128 held stable → within 13 edges: HEX2/1/0 = 0x24/0x12/0x12 and HEX5/4/3 = 0x79/0x24/0x00. No HEX change before UPDATE.
- Sweep seq 0..9, each held until busy falls → HEX0 walks 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10. HEX1 and HEX2 stay 0x7F.
- seq changes 5→37 three cycles after busy rises → first conversion displays 5 (HEX0=0x12). A second busy pulse follows immediately, then HEX1/0 = 0x30/0x78.
- BLANK_LZ=0, seq=7, freq=40 → HEX2/1/0 = 0x40/0x40/0x78 and HEX5/4/3 = 0x40/0x19/0x40.
- Reset asserted mid-SHIFT → HEX go to 0x7F and busy=0 asynchronously. After release, a full reconversion of the current inputs completes in 9 busy cycles.

Source files
------------

// File: rtl/seq_freq_display.sv
// Binary-to-decimal display driver: seq_num on HEX2..HEX0, freq_num on HEX5..HEX3, via serial double-dabble.
// Latency: W+2 cycles from leaving IDLE to HEX update; pin-to-HEX within W+5 edges (2-flop synchronizer included).
// No backpressure: input changes during a conversion are picked up by a fresh conversion on return to IDLE.
module seq_freq_display #(
    parameter int SEQ_W    = 8,
    parameter int FREQ_W   = 8,
    parameter int BLANK_LZ = 1
) (
    input  logic              CLK_50,
    input  logic              reset,
    input  logic [SEQ_W-1:0]  seq_num,
    input  logic [FREQ_W-1:0] freq_num,
    output logic              busy,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5
);

    // Both operands are shifted in lockstep, so one counter serves the wider of the two.
    localparam int W = (SEQ_W > FREQ_W) ? SEQ_W : FREQ_W;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;

    state_t state, state_nxt;

    logic [SEQ_W-1:0]  seq_meta, s_seq, last_seq;
    logic [FREQ_W-1:0] freq_meta, s_freq, last_freq;
    logic [W-1:0]      sr_seq, sr_freq;
    logic [11:0]       bcd_seq, bcd_freq;
    logic [3:0]        cnt;
    logic              valid;
    logic              changed;

    // Active-low segment pattern, bit6=g .. bit0=a; anything outside 0..9 shows blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to each nibble >= 5, then shift left taking in the next binary bit.
    function automatic logic [11:0] dd_step(input logic [11:0] b, input logic in_bit);
        logic [11:0] adj;
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return 12'(adj << 1) | {11'b0, in_bit};
    endfunction

    // Three-digit segment word {hundreds, tens, units}; units always shown.
    function automatic logic [20:0] disp(input logic [11:0] b);
        logic [6:0] hs, ts;
        hs = ((BLANK_LZ != 0) && (b[11:8] == 4'd0)) ? 7'h7F : seg7(b[11:8]);
        ts = ((BLANK_LZ != 0) && (b[11:8] == 4'd0) && (b[7:4] == 4'd0)) ? 7'h7F : seg7(b[7:4]);
        return {hs, ts, seg7(b[3:0])};
    endfunction

    // Two-flop synchronizer from the slow_clk domain; left unreset so the current inputs are
    // already settled when reset releases and the first conversion snapshots them.
    always_ff @(posedge CLK_50) begin
        seq_meta  <= seq_num;
        s_seq     <= seq_meta;
        freq_meta <= freq_num;
        s_freq    <= freq_meta;
    end

    assign changed = ({s_seq, s_freq} != {last_seq, last_freq});

    // State register.
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and busy decode; busy covers LOAD plus the W shift cycles.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE:    if (!valid || changed) state_nxt = LOAD;
            LOAD: begin
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == 4'd1) state_nxt = UPDATE;
            end
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath and display registers; HEX only moves in UPDATE so partial BCD never shows.
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            sr_seq    <= '0;
            sr_freq   <= '0;
            bcd_seq   <= '0;
            bcd_freq  <= '0;
            last_seq  <= '0;
            last_freq <= '0;
            cnt       <= '0;
            valid     <= 1'b0;
            HEX0      <= 7'h7F;
            HEX1      <= 7'h7F;
            HEX2      <= 7'h7F;
            HEX3      <= 7'h7F;
            HEX4      <= 7'h7F;
            HEX5      <= 7'h7F;
        end else begin
            case (state)
                LOAD: begin
                    sr_seq    <= W'(s_seq);
                    sr_freq   <= W'(s_freq);
                    last_seq  <= s_seq;
                    last_freq <= s_freq;
                    bcd_seq   <= '0;
                    bcd_freq  <= '0;
                    cnt       <= 4'(W);
                end
                SHIFT: begin
                    bcd_seq  <= dd_step(bcd_seq, sr_seq[W-1]);
                    bcd_freq <= dd_step(bcd_freq, sr_freq[W-1]);
                    sr_seq   <= sr_seq << 1;
                    sr_freq  <= sr_freq << 1;
                    cnt      <= cnt - 4'd1;
                end
                UPDATE: begin
                    {HEX2, HEX1, HEX0} <= disp(bcd_seq);
                    {HEX5, HEX4, HEX3} <= disp(bcd_freq);
                    valid              <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
